dmem_arbiter: RTL and testbench

- Shares the single-ported data memory (9-bit word address, 32-bit data) between two requesters: the core load/store unit (port 0) and a debug/program-loader port (port 1).
- Sits between the RISCV pipeline's memory stage and the data memory instance.
- The memory-side signals are the ones the bench monitors: WriteEnable, ReadEnable, Address, WRData and RDData.
- Enforces one outstanding read, returns read data to the correct requester, and arbitrates either round-robin or fixed-priority.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_rr_pick.sv | 28 ++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker: round-robin on last grant, or fixed priority to port 0.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  port_id_t   last,
  input  logic       prio_mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      // On a tie port 0 wins unless it was the one granted last.
      if (prio_mode || (last == 1'b1)) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the load/store unit (port 0)
// and the debug/loader port (port 1), with one outstanding read at a time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W    = dmem_arb_pkg::DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter bit          PRIO_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              WriteEnable,
  output logic              ReadEnable,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WRData,
  input  logic [DATA_W-1:0] RDData
);

  localparam int unsigned CNT_W = 3;

  arb_state_t        state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  port_id_t          owner, ownerNext;
  port_id_t          lastGnt, lastGntNext;
  logic [ADDR_W-1:0] addrHold, addrHoldNext;
  logic [DATA_W-1:0] wdataHold, wdataHoldNext;

  logic [1:0]        pick;
  logic              rdDone;
  logic              grantOk;
  port_id_t          winner;
  logic              winWe;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;

  dmem_rr_pick uPick (
    .req0      (req0),
    .req1      (req1),
    .last      (lastGnt),
    .prio_mode (1'(PRIO_MODE)),
    .grant     (pick)
  );

  // The rvalid cycle of an outstanding read also reopens the grant window.
  assign rdDone  = (state == RD_WAIT) && (cnt == CNT_W'(1));
  assign grantOk = (state == IDLE) || rdDone;
  assign winner  = port_id_t'(pick[1]);
  assign winWe   = pick[1] ? we1 : we0;
  assign winAddr = pick[1] ? addr1 : addr0;
  assign winData = pick[1] ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      lastGnt   <= 1'b1;
      addrHold  <= '0;
      wdataHold <= '0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      owner     <= ownerNext;
      lastGnt   <= lastGntNext;
      addrHold  <= addrHoldNext;
      wdataHold <= wdataHoldNext;
    end
  end

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    ownerNext     = owner;
    lastGntNext   = lastGnt;
    addrHoldNext  = addrHold;
    wdataHoldNext = wdataHold;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    rvalid0       = 1'b0;
    rvalid1       = 1'b0;
    rdata         = '0;
    WriteEnable   = 1'b0;
    ReadEnable    = 1'b0;
    Address       = addrHold;
    WRData        = wdataHold;

    if (rdDone) begin
      rvalid0   = (owner == 1'b0);
      rvalid1   = (owner == 1'b1);
      rdata     = RDData;
      stateNext = IDLE;
      cntNext   = '0;
    end else if (state == RD_WAIT) begin
      cntNext = cnt - CNT_W'(1);
    end

    if (grantOk && (pick != 2'b00)) begin
      gnt0          = pick[0];
      gnt1          = pick[1];
      WriteEnable   = winWe;
      ReadEnable    = !winWe;
      Address       = winAddr;
      WRData        = winData;
      addrHoldNext  = winAddr;
      wdataHoldNext = winData;
      lastGntNext   = winner;
      // A read accepted in the return cycle of the previous one reloads the wait.
      if (!winWe) begin
        stateNext = RD_WAIT;
        cntNext   = CNT_W'(RD_LAT);
        ownerNext = winner;
      end
    end

    if (rst) begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      rvalid0     = 1'b0;
      rvalid1     = 1'b0;
      rdata       = '0;
      WriteEnable = 1'b0;
      ReadEnable  = 1'b0;
      Address     = '0;
      WRData      = '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT=1 RR, RD_LAT=3 RR, RD_LAT=1 fixed
// priority), each with its own memory, checked against a cycle-count reference model.
module tb_dmem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [NI-1:0]  req0, req1, we0, we1;
  logic [8:0]     addr0 [NI];
  logic [8:0]     addr1 [NI];
  logic [31:0]    wdata0 [NI];
  logic [31:0]    wdata1 [NI];
  logic [NI-1:0]  gnt0, gnt1, rvalid0, rvalid1, WriteEnable, ReadEnable;
  logic [8:0]     Address [NI];
  logic [31:0]    WRData [NI];
  logic [31:0]    rdata [NI];
  logic [31:0]    RDData [NI];

  function automatic logic [31:0] initWord(input int g, input int i);
    return 32'h5A00_0000 | (32'(g) << 16) | 32'(i);
  endfunction

  function automatic int latOf(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic bit prioOf(input int g);
    return (g == 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gI
    localparam int unsigned L = (g == 1) ? 3 : 1;
    localparam bit          P = (g == 2);
    logic [31:0] mem [512];
    logic [31:0] dl [4];
    logic        capWe = 1'b0;
    logic        capRe = 1'b0;
    logic [8:0]  capA  = '0;
    logic [31:0] capD  = '0;

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = initWord(g, i);
      for (int i = 0; i < 4; i++) dl[i] = '0;
    end

    always @(negedge clk) begin
      capWe <= WriteEnable[g];
      capRe <= ReadEnable[g];
      capA  <= Address[g];
      capD  <= WRData[g];
    end

    always @(posedge clk) begin
      dl[0] <= capRe ? mem[capA] : 32'h0;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
      if (capWe) mem[capA] = capD;
    end

    assign RDData[g] = dl[L-1];

    dmem_arbiter #(
      .ADDR_W    (9),
      .DATA_W    (32),
      .RD_LAT    (L),
      .PRIO_MODE (P)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0[g]),
      .req1        (req1[g]),
      .we0         (we0[g]),
      .we1         (we1[g]),
      .addr0       (addr0[g]),
      .addr1       (addr1[g]),
      .wdata0      (wdata0[g]),
      .wdata1      (wdata1[g]),
      .gnt0        (gnt0[g]),
      .gnt1        (gnt1[g]),
      .rvalid0     (rvalid0[g]),
      .rvalid1     (rvalid1[g]),
      .rdata       (rdata[g]),
      .WriteEnable (WriteEnable[g]),
      .ReadEnable  (ReadEnable[g]),
      .Address     (Address[g]),
      .WRData      (WRData[g]),
      .RDData      (RDData[g])
    );
  end

  // Reference model: grant window and read return tracked as absolute cycle numbers.
  int          nPass, nFail, nChk, cyc;
  int          mLast [NI];
  int          mFree [NI];
  int          mDue  [NI];
  int          mPort [NI];
  logic [31:0] mData [NI];
  logic [31:0] shadow [NI][512];

  logic [NI-1:0] sG0, sG1, sRv0, sRv1, sWe, sRe;
  logic [31:0]   sRd [NI];
  logic [8:0]    sAddr [NI];

  int   c0, c1, p0;
  logic rvSeen;
  logic act;

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s inst%0d cycle %0d: observed=%h expected=%h", tag, g, cyc, obs, exp);
    end
  endtask

  task automatic setReq(input int g, input int p, input logic r, input logic w,
                        input logic [8:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0[g] = r; we0[g] = w; addr0[g] = a; wdata0[g] = d;
    end else begin
      req1[g] = r; we1[g] = w; addr1[g] = a; wdata1[g] = d;
    end
  endtask

  task automatic step();
    int          w;
    logic        wWe;
    logic [8:0]  wA;
    logic [31:0] wD;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      sG0[g] = gnt0[g];  sG1[g] = gnt1[g];
      sRv0[g] = rvalid0[g]; sRv1[g] = rvalid1[g];
      sWe[g] = WriteEnable[g]; sRe[g] = ReadEnable[g];
      sRd[g] = rdata[g]; sAddr[g] = Address[g];
      if (rst) begin
        chk("rst_gnt0", g, 32'(gnt0[g]), 32'd0);
        chk("rst_gnt1", g, 32'(gnt1[g]), 32'd0);
        chk("rst_rvalid0", g, 32'(rvalid0[g]), 32'd0);
        chk("rst_rvalid1", g, 32'(rvalid1[g]), 32'd0);
        chk("rst_we", g, 32'(WriteEnable[g]), 32'd0);
        chk("rst_re", g, 32'(ReadEnable[g]), 32'd0);
        chk("rst_addr", g, 32'(Address[g]), 32'd0);
        chk("rst_wrdata", g, WRData[g], 32'd0);
        chk("rst_rdata", g, rdata[g], 32'd0);
        mLast[g] = 1; mFree[g] = 0; mDue[g] = -1;
      end else begin
        w = -1;
        if (cyc >= mFree[g]) begin
          if (req0[g] && req1[g]) w = prioOf(g) ? 0 : ((mLast[g] == 0) ? 1 : 0);
          else if (req0[g]) w = 0;
          else if (req1[g]) w = 1;
        end
        chk("gnt0", g, 32'(gnt0[g]), 32'(w == 0));
        chk("gnt1", g, 32'(gnt1[g]), 32'(w == 1));
        chk("rvalid0", g, 32'(rvalid0[g]), 32'(mDue[g] == cyc && mPort[g] == 0));
        chk("rvalid1", g, 32'(rvalid1[g]), 32'(mDue[g] == cyc && mPort[g] == 1));
        if (mDue[g] == cyc) chk("rdata", g, rdata[g], mData[g]);
        if (w >= 0) begin
          wWe = (w == 1) ? we1[g] : we0[g];
          wA  = (w == 1) ? addr1[g] : addr0[g];
          wD  = (w == 1) ? wdata1[g] : wdata0[g];
          chk("we", g, 32'(WriteEnable[g]), 32'(wWe));
          chk("re", g, 32'(ReadEnable[g]), 32'(!wWe));
          chk("addr", g, 32'(Address[g]), 32'(wA));
          if (wWe) begin
            chk("wrdata", g, WRData[g], wD);
            shadow[g][wA] = wD;
          end else begin
            mDue[g]  = cyc + latOf(g);
            mFree[g] = cyc + latOf(g);
            mPort[g] = w;
            mData[g] = shadow[g][wA];
          end
          mLast[g] = w;
        end else begin
          chk("idle_we", g, 32'(WriteEnable[g]), 32'd0);
          chk("idle_re", g, 32'(ReadEnable[g]), 32'd0);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nPass = 0; nFail = 0; nChk = 0; cyc = 0;
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 512; i++) shadow[g][i] = initWord(g, i);
      mLast[g] = 1; mFree[g] = 0; mDue[g] = -1; mPort[g] = 0; mData[g] = '0;
      setReq(g, 0, 1'b0, 1'b0, 9'd0, 32'd0);
      setReq(g, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;

    // Simultaneous writes: port 0 first, then port 1, one cycle each.
    setReq(0, 0, 1'b1, 1'b1, 9'd5, 32'hDEADBEEF);
    setReq(0, 1, 1'b1, 1'b1, 9'd7, 32'h12345678);
    step();
    chk("t1_gnt0", 0, 32'(sG0[0]), 32'd1);
    chk("t1_we", 0, 32'(sWe[0]), 32'd1);
    chk("t1_addr0", 0, 32'(sAddr[0]), 32'd5);
    setReq(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t1_gnt1", 0, 32'(sG1[0]), 32'd1);
    chk("t1_addr1", 0, 32'(sAddr[0]), 32'd7);
    setReq(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t1_gnt_done", 0, 32'(sG0[0] | sG1[0]), 32'd0);

    // Back-to-back reads with RD_LAT=1.
    setReq(0, 0, 1'b1, 1'b0, 9'd5, 32'd0);
    step();
    chk("t2_gnt0", 0, 32'(sG0[0]), 32'd1);
    chk("t2_re", 0, 32'(sRe[0]), 32'd1);
    setReq(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    setReq(0, 1, 1'b1, 1'b0, 9'd7, 32'd0);
    step();
    chk("t2_rv0", 0, 32'(sRv0[0]), 32'd1);
    chk("t2_rd0", 0, sRd[0], 32'hDEADBEEF);
    chk("t2_gnt1", 0, 32'(sG1[0]), 32'd1);
    setReq(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t2_rv1", 0, 32'(sRv1[0]), 32'd1);
    chk("t2_rd1", 0, sRd[0], 32'h12345678);

    // RD_LAT=3: port 1 blocked until the return cycle of port 0's read.
    setReq(1, 0, 1'b1, 1'b0, 9'd9, 32'd0);
    setReq(1, 1, 1'b1, 1'b0, 9'd20, 32'd0);
    step();
    chk("t3_gnt0", 1, 32'(sG0[1]), 32'd1);
    setReq(1, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t3_hold_a", 1, 32'(sG1[1]), 32'd0);
    step();
    chk("t3_hold_b", 1, 32'(sG1[1]), 32'd0);
    step();
    chk("t3_rv0", 1, 32'(sRv0[1]), 32'd1);
    chk("t3_rd0", 1, sRd[1], initWord(1, 9));
    chk("t3_gnt1", 1, 32'(sG1[1]), 32'd1);
    setReq(1, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    step();
    step();
    chk("t3_rv1", 1, 32'(sRv1[1]), 32'd1);
    chk("t3_rd1", 1, sRd[1], initWord(1, 20));

    // Continuous contention: round-robin alternates, fixed priority starves port 1.
    c0 = 0; c1 = 0; p0 = 0;
    setReq(0, 0, 1'b1, 1'b1, 9'd40, 32'h0000_AAAA);
    setReq(0, 1, 1'b1, 1'b1, 9'd41, 32'h0000_BBBB);
    setReq(2, 0, 1'b1, 1'b1, 9'd40, 32'h0000_CCCC);
    setReq(2, 1, 1'b1, 1'b1, 9'd41, 32'h0000_DDDD);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_alt", 0, 32'(sG0[0]), 32'((i % 2) == 0));
      c0 += int'(sG0[0]);
      c1 += int'(sG1[0]);
      p0 += int'(sG0[2]);
    end
    chk("t4_rr_cnt0", 0, 32'(c0), 32'd4);
    chk("t4_rr_cnt1", 0, 32'(c1), 32'd4);
    chk("t4_prio_cnt0", 2, 32'(p0), 32'd8);
    setReq(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    setReq(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    setReq(2, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    setReq(2, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();

    // Reset while port 1's read is in flight: its rvalid must never appear.
    setReq(1, 1, 1'b1, 1'b0, 9'd30, 32'd0);
    step();
    chk("t5_gnt1", 1, 32'(sG1[1]), 32'd1);
    setReq(1, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rvSeen = 1'b0;
    setReq(1, 0, 1'b1, 1'b1, 9'd50, 32'h1111_0000);
    setReq(1, 1, 1'b1, 1'b1, 9'd51, 32'h2222_0000);
    step();
    chk("t5_gnt0_after_rst", 1, 32'(sG0[1]), 32'd1);
    rvSeen = rvSeen | sRv1[1];
    setReq(1, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t5_gnt1_after_rst", 1, 32'(sG1[1]), 32'd1);
    rvSeen = rvSeen | sRv1[1];
    setReq(1, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      rvSeen = rvSeen | sRv1[1];
    end
    chk("t5_no_rv1", 1, 32'(rvSeen), 32'd0);

    // Write then read of the same word from the other port.
    setReq(0, 0, 1'b1, 1'b1, 9'd12, 32'hCAFEF00D);
    step();
    chk("t6_gnt0", 0, 32'(sG0[0]), 32'd1);
    setReq(0, 0, 1'b0, 1'b0, 9'd0, 32'd0);
    setReq(0, 1, 1'b1, 1'b0, 9'd12, 32'd0);
    step();
    chk("t6_gnt1", 0, 32'(sG1[0]), 32'd1);
    setReq(0, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    step();
    chk("t6_rv1", 0, 32'(sRv1[0]), 32'd1);
    chk("t6_rd1", 0, sRd[0], 32'hCAFEF00D);

    // Random traffic with withdrawals and one mid-run reset.
    for (int n = 0; n < 2000; n++) begin
      for (int g = 0; g < NI; g++) begin
        for (int p = 0; p < 2; p++) begin
          act = (p == 1) ? req1[g] : req0[g];
          if (act && ($urandom_range(15) == 0))
            setReq(g, p, 1'b0, 1'b0, 9'd0, 32'd0);
          else if (!act && ($urandom_range(1) == 0))
            setReq(g, p, 1'b1, 1'($urandom_range(1)), 9'($urandom_range(31)), $urandom);
        end
      end
      rst = (n == 1000);
      step();
      for (int g = 0; g < NI; g++) begin
        if (sG0[g]) setReq(g, 0, 1'b0, 1'b0, 9'd0, 32'd0);
        if (sG1[g]) setReq(g, 1, 1'b0, 1'b0, 9'd0, 32'd0);
      end
    end
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      setReq(g, 0, 1'b0, 1'b0, 9'd0, 32'd0);
      setReq(g, 1, 1'b0, 1'b0, 9'd0, 32'd0);
    end
    for (int i = 0; i < 5; i++) step();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
